// File: rtl/reg_file_p.sv
// Decode-stage CPU register file: one write port, two registered read ports,
// optional read-after-write bypass, hardwired zero entry and a run-time clear sweep.
module reg_file_p #(
   parameter int WIDTH    = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             RegW,
   input  logic [AW-1:0]    DR,
   input  logic [WIDTH-1:0] Reg_In,
   input  logic [AW-1:0]    SR1,
   input  logic [AW-1:0]    SR2,
   output logic [WIDTH-1:0] ReadReg1,
   output logic [WIDTH-1:0] ReadReg2,
   input  logic             Clr,
   output logic             Busy,
   output logic             ClrDone
);

   localparam int DEPTH = 2**AW;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SWEEP = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state;
   logic [AW-1:0]    sweep_ptr;
   logic             sweep_busy;
   logic             wr_en;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd1_nxt;
   logic [WIDTH-1:0] rd2_nxt;
   logic [WIDTH-1:0] rd1_p1;
   logic [WIDTH-1:0] rd2_p1;

   // Resolves what a read port captures at the coming edge; order of the checks matters.
   function automatic logic [WIDTH-1:0] resolve_read(
      input logic [AW-1:0]    sr,
      input logic [WIDTH-1:0] stored,
      input logic             regw,
      input logic [AW-1:0]    dr,
      input logic [WIDTH-1:0] din,
      input logic             busy,
      input logic [AW-1:0]    ptr
   );
      if (ZERO_REG != 0 && sr == '0)
         return '0;
      if (BYPASS != 0 && regw && !busy && dr == sr)
         return din;
      if (BYPASS != 0 && busy && sr == ptr)
         return '0;
      return stored;
   endfunction

   assign sweep_busy = (state == S_SWEEP);
   assign wr_en      = RegW && !sweep_busy && !(ZERO_REG != 0 && DR == '0);

   always_comb begin
      rd1_nxt = resolve_read(SR1, mem[SR1], RegW, DR, Reg_In, sweep_busy, sweep_ptr);
      rd2_nxt = resolve_read(SR2, mem[SR2], RegW, DR, Reg_In, sweep_busy, sweep_ptr);
   end

   // Clear sequencer: the pointer only returns to zero through DONE.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= S_IDLE;
         sweep_ptr <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (Clr) begin
                  state     <= S_SWEEP;
                  sweep_ptr <= '0;
               end
            end
            S_SWEEP: begin
               if (&sweep_ptr) begin
                  state     <= S_DONE;
                  sweep_ptr <= '0;
               end else begin
                  sweep_ptr <= sweep_ptr + AW'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Sweep and port writes never collide: port writes are dropped while sweeping.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (sweep_busy) begin
         mem[sweep_ptr] <= '0;
      end else if (wr_en) begin
         mem[DR] <= Reg_In;
      end
   end

   // Stage p1: registered read data
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd1_p1 <= '0;
         rd2_p1 <= '0;
      end else begin
         rd1_p1 <= rd1_nxt;
         rd2_p1 <= rd2_nxt;
      end
   end

   assign ReadReg1 = rd1_p1;
   assign ReadReg2 = rd2_p1;
   assign Busy     = sweep_busy;
   assign ClrDone  = (state == S_DONE);

endmodule

// File: tb/tb_reg_file_p.sv
// Scoreboard bench for reg_file_p: one instance with zero-reg + bypass, one plain
// instance without either, both driven from the same stimulus.
module tb_reg_file_p;

   localparam int AW    = 5;
   localparam int WIDTH = 32;
   localparam int DEPTH = 32;

   logic             CLK    = 1'b0;
   logic             RST_N  = 1'b0;
   logic             RegW   = 1'b0;
   logic             Clr    = 1'b0;
   logic [AW-1:0]    DR     = '0;
   logic [AW-1:0]    SR1    = '0;
   logic [AW-1:0]    SR2    = '0;
   logic [WIDTH-1:0] Reg_In = '0;

   logic [WIDTH-1:0] rr1_a, rr2_a, rr1_b, rr2_b;
   logic             busy_a, done_a, busy_b, done_b;

   always #5 CLK = ~CLK;

   reg_file_p #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .CLK(CLK), .RST_N(RST_N), .RegW(RegW), .DR(DR), .Reg_In(Reg_In),
      .SR1(SR1), .SR2(SR2), .ReadReg1(rr1_a), .ReadReg2(rr2_a),
      .Clr(Clr), .Busy(busy_a), .ClrDone(done_a)
   );

   reg_file_p #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(0), .BYPASS(0)) dut_b (
      .CLK(CLK), .RST_N(RST_N), .RegW(RegW), .DR(DR), .Reg_In(Reg_In),
      .SR1(SR1), .SR2(SR2), .ReadReg1(rr1_b), .ReadReg2(rr2_b),
      .Clr(Clr), .Busy(busy_b), .ClrDone(done_b)
   );

   typedef struct {
      logic [31:0] a1, a2, b1, b2;
      logic        busy, done;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem_a [DEPTH];
   logic [31:0] mem_b [DEPTH];
   int          m_state = 0;   // 0 idle, 1 sweeping, 2 done
   int          m_ptr   = 0;
   int          n_vec   = 0;
   int          n_err   = 0;
   int          busy_cnt = 0;
   int          done_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      m_state = 0;
      m_ptr   = 0;
   endtask

   // Expected capture for the zero-reg + bypass instance.
   function automatic logic [31:0] model_rd_a(input logic [AW-1:0] s, input logic regw,
                                              input logic [AW-1:0] dr, input logic [31:0] din);
      logic sweeping;
      sweeping = (m_state == 1);
      if (s == '0)                       return 32'h0;
      if (regw && !sweeping && dr == s)  return din;
      if (sweeping && int'(s) == m_ptr)  return 32'h0;
      return mem_a[s];
   endfunction

   task automatic drive(input logic regw, input logic [AW-1:0] dr, input logic [31:0] din,
                        input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic clr);
      exp_t e;
      logic sweeping;
      @(negedge CLK);
      RegW = regw; DR = dr; Reg_In = din; SR1 = s1; SR2 = s2; Clr = clr;
      sweeping = (m_state == 1);
      e.a1 = model_rd_a(s1, regw, dr, din);
      e.a2 = model_rd_a(s2, regw, dr, din);
      e.b1 = mem_b[s1];
      e.b2 = mem_b[s2];
      if (regw && !sweeping) begin
         if (dr != '0) mem_a[dr] = din;
         mem_b[dr] = din;
      end
      if (m_state == 0) begin
         if (clr) begin
            m_state = 1;
            m_ptr   = 0;
         end
      end else if (m_state == 1) begin
         mem_a[m_ptr] = '0;
         mem_b[m_ptr] = '0;
         if (m_ptr == DEPTH - 1) begin
            m_state = 2;
            m_ptr   = 0;
         end else begin
            m_ptr++;
         end
      end else begin
         m_state = 0;
      end
      e.busy = (m_state == 1);
      e.done = (m_state == 2);
      exp_q.push_back(e);
   endtask

   task automatic idle_read(input logic [AW-1:0] s1, input logic [AW-1:0] s2);
      drive(1'b0, '0, 32'h0, s1, s2, 1'b0);
   endtask

   always @(posedge CLK) begin : monitor
      exp_t e;
      #1;
      if (busy_a) busy_cnt++;
      if (done_a) done_cnt++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_val("rd1_a", rr1_a, e.a1);
         check_val("rd2_a", rr2_a, e.a2);
         check_val("rd1_b", rr1_b, e.b1);
         check_val("rd2_b", rr2_b, e.b2);
         check_val("busy_a", 32'(busy_a), 32'(e.busy));
         check_val("busy_b", 32'(busy_b), 32'(e.busy));
         check_val("done_a", 32'(done_a), 32'(e.done));
         check_val("done_b", 32'(done_b), 32'(e.done));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      SR1 = 5'd3;
      SR2 = 5'd31;
      @(posedge CLK); @(posedge CLK); #1;
      check_val("rst_rd1_a", rr1_a, 32'h0);
      check_val("rst_rd2_a", rr2_a, 32'h0);
      check_val("rst_rd1_b", rr1_b, 32'h0);
      check_val("rst_busy", 32'(busy_a), 32'h0);
      check_val("rst_done", 32'(done_a), 32'h0);
      @(negedge CLK);
      RST_N = 1'b1;

      // Plain write then read, and writes to entry 0.
      drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd1, 1'b0);
      idle_read(5'd5, 5'd6);
      drive(1'b1, 5'd0, 32'h00001234, 5'd2, 5'd3, 1'b0);
      idle_read(5'd5, 5'd0);

      // Same-cycle write/read of entry 7.
      drive(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b0);
      idle_read(5'd7, 5'd5);

      // Fill every non-zero entry with index+1, then read all back.
      for (int i = 1; i < DEPTH; i++)
         drive(1'b1, AW'(i), 32'(i + 1), AW'(i), AW'(i - 1), 1'b0);
      for (int i = 0; i < DEPTH; i++)
         idle_read(AW'(i), AW'(DEPTH - 1 - i));

      // Clear sweep with a dropped write and a second Clr mid-sweep.
      busy_cnt = 0;
      done_cnt = 0;
      drive(1'b0, '0, 32'h0, 5'd1, 5'd2, 1'b1);
      for (int j = 0; j < 35; j++)
         drive(j == 5, 5'd9, 32'hDEAD0009, AW'(j), AW'(DEPTH - 1 - j), j == 10);
      @(posedge CLK); #2;
      check_val("sweep_busy_len", 32'(busy_cnt), 32'd32);
      check_val("sweep_done_cnt", 32'(done_cnt), 32'd1);
      for (int i = 0; i < DEPTH; i++)
         idle_read(AW'(i), AW'(i ^ 1));

      // Write and Clr together in idle: write lands, then gets swept.
      drive(1'b1, 5'd4, 32'h000000FF, 5'd4, 5'd4, 1'b1);
      for (int j = 0; j < 34; j++)
         idle_read(5'd4, AW'(j));
      idle_read(5'd4, 5'd4);

      // Reset in the middle of a sweep.
      for (int i = 1; i < 8; i++)
         drive(1'b1, AW'(i), 32'hC0DE0000 + 32'(i), AW'(i), 5'd0, 1'b0);
      busy_cnt = 0;
      done_cnt = 0;
      drive(1'b0, '0, 32'h0, 5'd1, 5'd2, 1'b1);
      for (int j = 0; j < 10; j++)
         idle_read(5'd6, 5'd7);
      @(negedge CLK);
      RegW = 1'b0; Clr = 1'b0; SR1 = 5'd6; SR2 = 5'd7;
      #2 RST_N = 1'b0;
      #1;
      check_val("mid_rst_busy", 32'(busy_a), 32'h0);
      check_val("mid_rst_done", 32'(done_a), 32'h0);
      check_val("mid_rst_rd1", rr1_a, 32'h0);
      check_val("mid_rst_rd2_b", rr2_b, 32'h0);
      model_reset();
      @(posedge CLK); @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      for (int i = 0; i < DEPTH; i++)
         idle_read(AW'(i), AW'(DEPTH - 1 - i));
      @(posedge CLK); #2;
      check_val("mid_rst_no_done", 32'(done_cnt), 32'd0);

      // Fresh sweep after reset runs its full length.
      busy_cnt = 0;
      done_cnt = 0;
      drive(1'b0, '0, 32'h0, 5'd0, 5'd0, 1'b1);
      for (int j = 0; j < 35; j++)
         idle_read(AW'(j), 5'd3);
      @(posedge CLK); #2;
      check_val("resweep_busy_len", 32'(busy_cnt), 32'd32);
      check_val("resweep_done_cnt", 32'(done_cnt), 32'd1);

      @(posedge CLK); #2;
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
